// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and the decode hazard unit.
// busy_next() is the single source of the scoreboard priority rule.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0]          xword_t;

  // Flush beats a new producer, a new producer beats a retiring write.
  function automatic logic busy_next(input logic cur, input logic flush, input logic alloc_hit,
                                     input logic wr_hit);
    return flush ? 1'b0 : alloc_hit ? 1'b1 : wr_hit ? 1'b0 : cur;
  endfunction

endpackage

// File: rtl/regfile_rport.sv
// One registered read port: zero-register forcing, write-first bypass, and output
// registers for data, index and busy that hold while the port is disabled.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned AW       = $clog2(NREGS_DEFAULT),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_en_i,
  input  logic [AW-1:0]   rd_sel_i,
  input  logic [XLEN-1:0] arr_data_i,
  input  logic            busy_next_i,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_sel_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [AW-1:0]   rd_sel_o,
  output logic            rd_busy_o
);

  logic            w_is_zero;
  logic            w_wr_hit;
  logic [XLEN-1:0] w_data;

  logic [XLEN-1:0] r_data;
  logic [AW-1:0]   r_sel;
  logic            r_busy;

  always_comb begin
    w_is_zero = ZERO_REG && (rd_sel_i == '0);
    w_wr_hit  = we_i && (wr_sel_i == rd_sel_i);
    // Zero register wins even over a same-cycle write aimed at it.
    w_data    = w_is_zero ? '0 : (w_wr_hit ? wr_data_i : arr_data_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= '0;
      r_busy <= 1'b0;
    end else if (rd_en_i) begin
      r_data <= w_data;
      r_sel  <= rd_sel_i;
      r_busy <= busy_next_i;
    end
  end

  assign rd_data_o = r_data;
  assign rd_sel_o  = r_sel;
  assign rd_busy_o = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised NRP-read / 1-write integer register file with registered reads,
// write-first bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter int unsigned NRP      = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP-1:0]      rd_en_i,
  input  logic [NRP*AW-1:0]   rd_sel_i,
  output logic [NRP*XLEN-1:0] rd_data_o,
  output logic [NRP*AW-1:0]   rd_sel_o,
  output logic [NRP-1:0]      rd_busy_o,
  input  logic                we_i,
  input  logic [AW-1:0]       wr_sel_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                alloc_i,
  input  logic [AW-1:0]       alloc_sel_i,
  input  logic                flush_i
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_d;
  logic             w_wr_en;

  assign w_wr_en = we_i && !(ZERO_REG && (wr_sel_i == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[wr_sel_i] <= wr_data_i;
    end
  end

  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_busy_d[r] = busy_next(r_busy[r], flush_i, alloc_i && (alloc_sel_i == AW'(r)),
                              we_i && (wr_sel_i == AW'(r)));
    end
    if (ZERO_REG) begin
      w_busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rport
    logic [AW-1:0] w_sel;
    assign w_sel = rd_sel_i[p*AW +: AW];

    // Ports see next-cycle busy so a same-cycle alloc/write/flush is already visible.
    regfile_rport #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rport (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_en_i     (rd_en_i[p]),
      .rd_sel_i    (w_sel),
      .arr_data_i  (r_regs[w_sel]),
      .busy_next_i (w_busy_d[w_sel]),
      .we_i        (we_i),
      .wr_sel_i    (wr_sel_i),
      .wr_data_i   (wr_data_i),
      .rd_data_o   (rd_data_o[p*XLEN +: XLEN]),
      .rd_sel_o    (rd_sel_o[p*AW +: AW]),
      .rd_busy_o   (rd_busy_o[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic
// checked against an array-based model of the register file and scoreboard.
module tb_regfile_mp_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRP  = 2
);
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned HP    = NRP - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRP-1:0]      rd_en = '0;
  logic [NRP*AW-1:0]   rd_sel = '0;
  logic [NRP*XLEN-1:0] rd_data_o;
  logic [NRP*AW-1:0]   rd_sel_o;
  logic [NRP-1:0]      rd_busy_o;
  logic                we = 1'b0;
  logic [AW-1:0]       wr_sel = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                alloc = 1'b0;
  logic [AW-1:0]       alloc_sel = '0;
  logic                flush = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: architectural values, busy bits, and what each port should show.
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  logic [XLEN-1:0]  e_data [NRP];
  logic [AW-1:0]    e_sel  [NRP];
  logic             e_busy [NRP];

  regfile_mp_sb #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRP      (NRP),
    .ZERO_REG (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en_i     (rd_en),
    .rd_sel_i    (rd_sel),
    .rd_data_o   (rd_data_o),
    .rd_sel_o    (rd_sel_o),
    .rd_busy_o   (rd_busy_o),
    .we_i        (we),
    .wr_sel_i    (wr_sel),
    .wr_data_i   (wr_data),
    .alloc_i     (alloc),
    .alloc_sel_i (alloc_sel),
    .flush_i     (flush)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int p = 0; p < NRP; p++) begin
      e_data[p] = '0;
      e_sel[p]  = '0;
      e_busy[p] = 1'b0;
    end
  endtask

  task automatic idle();
    rd_en = '0;
    we    = 1'b0;
    alloc = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_sel(input int p, input int idx);
    rd_sel[p*AW +: AW] = AW'(idx);
  endtask

  // Advance one clock. A read returns the state the register file holds once this
  // cycle's write/alloc/flush have taken effect; x0 is never written and never busy.
  task automatic tick();
    logic [NREGS-1:0] nb;
    int unsigned      s;
    if (we && wr_sel != '0) m_regs[wr_sel] = wr_data;
    for (int r = 0; r < NREGS; r++) begin
      if (flush)                            nb[r] = 1'b0;
      else if (alloc && alloc_sel == AW'(r)) nb[r] = 1'b1;
      else if (we && wr_sel == AW'(r))       nb[r] = 1'b0;
      else                                   nb[r] = m_busy[r];
    end
    nb[0]  = 1'b0;
    m_busy = nb;
    for (int p = 0; p < NRP; p++) begin
      if (rd_en[p]) begin
        s         = rd_sel[p*AW +: AW];
        e_sel[p]  = AW'(s);
        e_data[p] = m_regs[s];
        e_busy[p] = m_busy[s];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    we = 1'b1; wr_sel = 5; wr_data = XLEN'(64'hA5A5_A5A5_5A5A_5A5A);
    alloc = 1'b1; alloc_sel = 5;
    rd_en = '1;
    for (int p = 0; p < NRP; p++) set_sel(p, 5);
    tick();
    wr_data = XLEN'(64'h1111_2222_3333_4444); alloc_sel = 6;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < NRP; p++) begin
      n_checks++;
      if (rd_data_o[p*XLEN +: XLEN] !== '0) begin
        n_errors++;
        $display("FAIL reset_data p%0d got %h want 0", p, rd_data_o[p*XLEN +: XLEN]);
      end
      n_checks++;
      if (rd_sel_o[p*AW +: AW] !== '0) begin
        n_errors++;
        $display("FAIL reset_sel p%0d got %0d want 0", p, rd_sel_o[p*AW +: AW]);
      end
      n_checks++;
      if (rd_busy_o[p] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_busy p%0d got %b want 0", p, rd_busy_o[p]);
      end
    end
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    #2;
    rd_en[0] = 1'b1; set_sel(0, 5);
    tick();
    n_checks++;
    if (rd_data_o[XLEN-1:0] !== '0 || rd_busy_o[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_x5 got data %h busy %b want 0 0", rd_data_o[XLEN-1:0], rd_busy_o[0]);
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1'b1; wr_sel = 5; wr_data = XLEN'(32'hDEAD_BEEF);
    tick();
    idle();
    rd_en[0] = 1'b1; set_sel(0, 5);
    tick();
    n_checks++;
    if (rd_data_o[XLEN-1:0] !== XLEN'(32'hDEAD_BEEF)) begin
      n_errors++;
      $display("FAIL wr_rd_data got %h want %h", rd_data_o[XLEN-1:0], XLEN'(32'hDEAD_BEEF));
    end
    n_checks++;
    if (rd_sel_o[AW-1:0] !== AW'(5)) begin
      n_errors++;
      $display("FAIL wr_rd_sel got %0d want 5", rd_sel_o[AW-1:0]);
    end
  endtask

  task automatic test_bypass_all();
    idle();
    we = 1'b1; wr_sel = 7; wr_data = XLEN'(32'h1234);
    rd_en = '1;
    for (int p = 0; p < NRP; p++) set_sel(p, 7);
    tick();
    for (int p = 0; p < NRP; p++) begin
      n_checks++;
      if (rd_data_o[p*XLEN +: XLEN] !== XLEN'(32'h1234)) begin
        n_errors++;
        $display("FAIL bypass p%0d got %h want %h", p, rd_data_o[p*XLEN +: XLEN], XLEN'(32'h1234));
      end
    end
  endtask

  task automatic test_zero_reg();
    idle();
    we = 1'b1; wr_sel = 0; wr_data = '1;
    alloc = 1'b1; alloc_sel = 0;
    rd_en = '1;
    for (int p = 0; p < NRP; p++) set_sel(p, 0);
    tick();
    for (int p = 0; p < NRP; p++) begin
      n_checks++;
      if (rd_data_o[p*XLEN +: XLEN] !== '0 || rd_busy_o[p] !== 1'b0) begin
        n_errors++;
        $display("FAIL zero_same p%0d got data %h busy %b want 0 0", p,
                 rd_data_o[p*XLEN +: XLEN], rd_busy_o[p]);
      end
    end
    idle();
    rd_en = '1;
    tick();
    for (int p = 0; p < NRP; p++) begin
      n_checks++;
      if (rd_data_o[p*XLEN +: XLEN] !== '0 || rd_busy_o[p] !== 1'b0) begin
        n_errors++;
        $display("FAIL zero_later p%0d got data %h busy %b want 0 0", p,
                 rd_data_o[p*XLEN +: XLEN], rd_busy_o[p]);
      end
    end
  endtask

  task automatic test_busy();
    logic want [3];
    want[0] = 1'b1; want[1] = 1'b1; want[2] = 1'b0;
    for (int step = 0; step < 3; step++) begin
      idle();
      rd_en = '1;
      for (int p = 0; p < NRP; p++) set_sel(p, 3);
      alloc = (step < 2); alloc_sel = 3;
      we = (step > 0); wr_sel = 3; wr_data = XLEN'(32'h3300 + step);
      tick();
      for (int p = 0; p < NRP; p++) begin
        n_checks++;
        if (rd_busy_o[p] !== want[step]) begin
          n_errors++;
          $display("FAIL busy_step%0d p%0d got %b want %b", step, p, rd_busy_o[p], want[step]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int          idx [3];
    logic [XLEN-1:0] x4_before;
    idx[0] = 2; idx[1] = 4; idx[2] = 9;
    idle();
    we = 1'b1; wr_sel = 4; wr_data = XLEN'(32'h0444_0444);
    tick();
    x4_before = XLEN'(32'h0444_0444);
    idle(); alloc = 1'b1; alloc_sel = 4; tick();
    idle(); alloc = 1'b1; alloc_sel = 9; tick();
    idle(); alloc = 1'b1; alloc_sel = 2; flush = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      rd_en[0] = 1'b1; set_sel(0, idx[i]);
      tick();
      n_checks++;
      if (rd_busy_o[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_busy x%0d got %b want 0", idx[i], rd_busy_o[0]);
      end
      n_checks++;
      if (rd_data_o[XLEN-1:0] !== e_data[0]) begin
        n_errors++;
        $display("FAIL flush_data x%0d got %h want %h", idx[i], rd_data_o[XLEN-1:0], e_data[0]);
      end
    end
    n_checks++;
    if (m_regs[4] !== x4_before) begin
      n_errors++;
      $display("FAIL flush_x4 got %h want %h", m_regs[4], x4_before);
    end
  endtask

  task automatic test_hold();
    logic [XLEN-1:0] h_data;
    logic [AW-1:0]   h_sel;
    logic            h_busy;
    idle();
    we = 1'b1; wr_sel = 10; wr_data = XLEN'(32'hCAFE_0010);
    alloc = 1'b1; alloc_sel = 10;
    rd_en[HP] = 1'b1; set_sel(int'(HP), 10);
    tick();
    h_data = XLEN'(32'hCAFE_0010); h_sel = AW'(10); h_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle();
      rd_en = NRP'($urandom);
      rd_en[HP] = 1'b0;
      set_sel(int'(HP), 11 + c);
      we = 1'b1; wr_sel = AW'(10 + c); wr_data = XLEN'({$urandom, $urandom});
      alloc = 1'b1; alloc_sel = AW'(11 + c);
      tick();
      n_checks++;
      if (rd_data_o[HP*XLEN +: XLEN] !== h_data || rd_sel_o[HP*AW +: AW] !== h_sel ||
          rd_busy_o[HP] !== h_busy) begin
        n_errors++;
        $display("FAIL hold c%0d got %h/%0d/%b want %h/%0d/%b", c, rd_data_o[HP*XLEN +: XLEN],
                 rd_sel_o[HP*AW +: AW], rd_busy_o[HP], h_data, h_sel, h_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rd_en = NRP'($urandom);
      for (int p = 0; p < NRP; p++) set_sel(p, $urandom_range(0, 7));
      we        = $urandom_range(0, 2) != 0;
      wr_sel    = AW'($urandom_range(0, 7));
      wr_data   = XLEN'({$urandom, $urandom});
      alloc     = $urandom_range(0, 1) != 0;
      alloc_sel = AW'($urandom_range(0, 7));
      flush     = $urandom_range(0, 15) == 0;
      tick();
      for (int p = 0; p < NRP; p++) begin
        n_checks++;
        if (rd_data_o[p*XLEN +: XLEN] !== e_data[p] || rd_sel_o[p*AW +: AW] !== e_sel[p] ||
            rd_busy_o[p] !== e_busy[p]) begin
          n_errors++;
          $display("FAIL random c%0d p%0d got %h/%0d/%b want %h/%0d/%b", c, p,
                   rd_data_o[p*XLEN +: XLEN], rd_sel_o[p*AW +: AW], rd_busy_o[p],
                   e_data[p], e_sel[p], e_busy[p]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_write_read();
    test_bypass_all();
    test_zero_reg();
    test_busy();
    test_flush();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
